// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
// Shared defaults and helpers for the multi-channel button debouncer.
//   DEF_*      : default parameter values used by debounce_channel and
//                button_debounce_multi
//   cnt_width  : bits needed to hold the values 0..n inclusive
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

  localparam int DEF_N_CH          = 5;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 100_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 0;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: input synchroniser, counter-based stability filter,
// registered press/release pulses, long-press detection and auto-repeat.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   btn_raw   in   raw asynchronous pin
//   btn_deb   out  debounced level, 1 = pressed
//   btn_rise  out  one-cycle pulse in the first pressed cycle
//   btn_fall  out  one-cycle pulse in the first released cycle
//   btn_hold  out  high while the press has lasted >= HOLD_CYCLES
//   btn_rpt   out  one-cycle repeat pulses while held (0 if REPEAT_CYCLES=0)
// -----------------------------------------------------------------------------
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_deb,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_hold,
  output logic btn_rpt
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
  localparam logic          INVERT      = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   hold;

  assign s    = sync_q[SYNC_STAGES-1] ^ INVERT;
  assign hold = (hcnt_q == HOLD_MAX);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    // fill_q marks when the chain holds real pin samples. Until then the
    // reset zeros would read as "pressed" on an active-low channel.
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};

    cnt_d = '0;
    deb_d = deb_q;
    if (fill_q[SYNC_STAGES-1] && (s != deb_q)) begin
      if (cnt_q == STABLE_LAST) begin
        deb_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;

    // Zero in the first pressed cycle and cleared in the release cycle, so
    // btn_hold drops together with btn_fall.
    hcnt_d = '0;
    if (deb_d && deb_q) begin
      hcnt_d = hold ? hcnt_q : hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      hcnt_q <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign btn_deb  = deb_q;
  assign btn_rise = rise_q;
  assign btn_fall = fall_q;
  assign btn_hold = hold;

  if (REPEAT_CYCLES > 0) begin : g_rpt
    localparam int              RW       = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0]   RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;

    always_comb begin
      rcnt_d = '0;
      if (hold) begin
        rcnt_d = (rcnt_q == RPT_LAST) ? '0 : rcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt_q <= '0;
      end else begin
        rcnt_q <= rcnt_d;
      end
    end

    // rcnt_q is zero in the first hold cycle, giving the immediate pulse.
    assign btn_rpt = hold & (rcnt_q == '0);
  end else begin : g_no_rpt
    assign btn_rpt = 1'b0;
  end

endmodule

// File: rtl/button_debounce_multi.sv
// -----------------------------------------------------------------------------
// button_debounce_multi
// N_CH independent debounce channels between the board pushbutton pins and
// the control FSMs.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   btn_raw   in   [N_CH] raw asynchronous pins
//   btn_deb   out  [N_CH] debounced level, 1 = pressed
//   btn_rise  out  [N_CH] press pulses
//   btn_fall  out  [N_CH] release pulses
//   btn_hold  out  [N_CH] long-press level
//   btn_rpt   out  [N_CH] auto-repeat pulses
// -----------------------------------------------------------------------------
module button_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_deb,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_hold,
  output logic [N_CH-1:0] btn_rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[i]),
      .btn_deb  (btn_deb[i]),
      .btn_rise (btn_rise[i]),
      .btn_fall (btn_fall[i]),
      .btn_hold (btn_hold[i]),
      .btn_rpt  (btn_rpt[i])
    );
  end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Multi-channel, parametrised successor to the single-button shift-register debouncer.
- Each channel has its own input synchroniser and a counter-based stability filter. A channel's debounced state changes only after the raw input has held a new level for STABLE_CYCLES consecutive clocks.
- Adds per-channel press/release pulses, long-press (hold) detection and optional auto-repeat.
- Sits between the board pushbutton pins and the control FSMs.

Parameters:
- N_CH, 5, number of independent button channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal: ≥2).
- STABLE_CYCLES, 100_000, consecutive clocks a new level must persist before the debounced state flips (legal: ≥1).
- ACTIVE_LOW, 0, 1 = raw pins are pressed-low; inputs are inverted after synchronisation.
- HOLD_CYCLES, 50_000_000, clocks of continuous debounced press before btn_hold asserts (legal: ≥1).
- REPEAT_CYCLES, 0, auto-repeat period while held; 0 disables repeat.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  N_CH  raw asynchronous button pins
- btn_deb  out  N_CH  debounced level, 1 = pressed
- btn_rise  out  N_CH  one-cycle pulse on press
- btn_fall  out  N_CH  one-cycle pulse on release
- btn_hold  out  N_CH  level, high while a press has lasted ≥ HOLD_CYCLES
- btn_rpt  out  N_CH  one-cycle repeat pulses while held

Behaviour:
- Reset: one clock (clk); rst is asynchronous, active-high. While rst=1, all synchroniser flops, counters and outputs are 0 (btn_deb=0, i.e. released, for either ACTIVE_LOW setting). Reset mid-press clears everything; after release of rst, a still-pressed button is re-qualified from scratch.
- Channels are fully independent; all logic per channel is identical.
- Synchroniser: SYNC_STAGES-deep flop chain; s = last stage, XOR ACTIVE_LOW.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - s == deb: cnt <= 0.
  - s != deb and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s != deb and cnt == STABLE_CYCLES-1: deb <= s, cnt <= 0.
- Glitch rejection: any return of s to deb before the flip resets cnt, so glitches shorter than STABLE_CYCLES are fully rejected.
- Latency: pin change to btn_deb change = SYNC_STAGES + STABLE_CYCLES clock edges. With STABLE_CYCLES=1, deb follows s one cycle later.
- Edge pulses:
  - btn_rise is high for exactly the cycle in which deb first reads 1.
  - btn_fall is high for exactly the cycle in which deb first reads 0.
  - Both are registered; they never assert together, and never at reset.
- Hold counter hcnt, width $clog2(HOLD_CYCLES+1):
  - Cleared while deb=0.
  - Increments each cycle deb=1, saturating at HOLD_CYCLES.
  - btn_hold = (hcnt == HOLD_CYCLES), so it rises HOLD_CYCLES cycles after btn_rise and drops in the same cycle as btn_fall.
- Repeat (REPEAT_CYCLES>0):
  - rcnt is cleared while btn_hold=0.
  - btn_rpt pulses in the first cycle btn_hold=1, then every REPEAT_CYCLES cycles while btn_hold stays 1.
  - rcnt wraps from REPEAT_CYCLES-1 to 0 and never overflows.
  - If REPEAT_CYCLES=0, btn_rpt is tied 0 and rcnt is not generated.
- Simultaneous events: a release qualifying in the same cycle a repeat would fire wins. deb falls, btn_fall=1, and btn_hold and btn_rpt are 0 that cycle.
- No output is combinational from btn_raw.

Decomposition:
- Package btn_debounce_pkg holds:
  - default constants: DEF_SYNC_STAGES, DEF_STABLE_CYCLES, DEF_HOLD_CYCLES;
  - a constant function cnt_width(n) returning $clog2(n+1).
- Sub-module debounce_channel implements one channel: synchroniser, stability counter, edge, hold and repeat logic.
- button_debounce_multi is a generate loop of N_CH debounce_channel instances.

Test Plan (N_CH=2, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0):
- Clean press: btn_raw[0] 0→1 at edge 0 and held → btn_deb[0]=1 and btn_rise[0]=1 after edge 6; btn_rise low after edge 7; btn_deb[1] stays 0.
- Glitch rejection: btn_raw[0] high for 3 cycles then low → btn_deb[0], btn_rise[0] never assert. Toggling every 2 cycles for 40 cycles → no output activity.
- Hold and repeat: press held 30 cycles after btn_rise → btn_hold rises 10 cycles after btn_rise; btn_rpt pulses at hold+0, +3, +6 … until release; release → btn_fall pulse, btn_hold=0 and btn_rpt=0 in that same cycle.
- ACTIVE_LOW=1: btn_raw idle 1, drive 0 → btn_deb=1 after 6 edges; idle-high pin out of reset produces no rise pulse.
- Reset mid-operation: assert rst asynchronously (between edges) while btn_hold[0]=1 → all outputs 0 immediately. Deassert with pin still pressed → btn_rise after 6 edges, btn_hold 10 cycles later.
- Independence: press both channels offset by 2 cycles → btn_rise[0] and btn_rise[1] pulses also offset by exactly 2 cycles.
